// File: rtl/sram_uart_bridge.sv
// rtl/sram_uart_bridge.sv - CPU data-port bridge to BaseRAM and the CPLD UART
//
// Multi-cycle bridge between the CPU data port and BaseRAM, which shares
// ram_data[7:0] with the CPLD UART. Accesses have programmable SRAM wait
// states and UART strobe width. ready_o pulses for one cycle when an access
// completes, and the CPU stalls until that pulse.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ce_i/we_i/addr_i/data_i/sel_i   CPU request (byte address, active-high byte enables)
//   data_o, ready_o         read data (held between reads), one-cycle completion pulse
//   ram_data                shared 32-bit BaseRAM bus; [7:0] also carries UART data
//   ram_addr, ram_be_n      BaseRAM word address and active-low byte enables
//   ram_ce_n/oe_n/we_n      BaseRAM strobes, active low
//   uart_rdn/uart_wrn       CPLD UART strobes, active low
//   uart_tbre/tsre/dataready  CPLD UART status inputs
module sram_uart_bridge #(
  parameter int          ADDR_W     = 20,
  parameter int          WAIT_RD    = 1,
  parameter int          WAIT_WR    = 1,
  parameter int          UART_PULSE = 2,
  parameter logic [31:0] UART_DATA  = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT  = 32'hBFD003FC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       data_o,
  output logic              ready_o,
  inout  wire  [31:0]       ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_tbre,
  input  logic              uart_tsre,
  input  logic              uart_dataready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAM_RD, S_RAM_WR, S_RAM_HOLD,
    S_UART_RD, S_UART_WR_WAIT, S_UART_WR, S_DONE
  } state_t;

  // Down-counter reload values: a state lasts (reload + 1) cycles.
  localparam logic [3:0] RD_CNT    = 4'(WAIT_RD);
  localparam logic [3:0] WR_CNT    = 4'(WAIT_WR);
  localparam logic [3:0] PULSE_CNT = 4'(UART_PULSE - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] wdata_q;
  logic        drv_lo_q;   // drive ram_data[7:0]
  logic        drv_hi_q;   // drive ram_data[31:8] (RAM writes only)

  assign ram_data[7:0]  = drv_lo_q ? wdata_q[7:0]  : {8{1'bz}};
  assign ram_data[31:8] = drv_hi_q ? wdata_q[31:8] : {24{1'bz}};

  wire uart_tx_idle = uart_tbre & uart_tsre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wdata_q  <= '0;
      drv_lo_q <= 1'b0;
      drv_hi_q <= 1'b0;
      data_o   <= '0;
      ready_o  <= 1'b0;
      ram_addr <= '0;
      ram_be_n <= 4'hF;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      uart_rdn <= 1'b1;
      uart_wrn <= 1'b1;
    end else begin
      ready_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ce_i) begin
            ram_addr <= addr_i[ADDR_W+1:2];
            wdata_q  <= data_i;
            if (addr_i == UART_STAT) begin
              // Status writes are accepted and ignored.
              if (!we_i) data_o <= {30'b0, uart_dataready, uart_tx_idle};
              state_q <= S_DONE;
              ready_o <= 1'b1;
            end else if (addr_i == UART_DATA) begin
              if (we_i) begin
                state_q <= S_UART_WR_WAIT;
              end else begin
                state_q  <= S_UART_RD;
                uart_rdn <= 1'b0;
                cnt_q    <= PULSE_CNT;
              end
            end else begin
              ram_be_n <= ~sel_i;
              ram_ce_n <= 1'b0;
              if (we_i) begin
                state_q  <= S_RAM_WR;
                ram_we_n <= 1'b0;
                drv_lo_q <= 1'b1;
                drv_hi_q <= 1'b1;
                cnt_q    <= WR_CNT;
              end else begin
                state_q  <= S_RAM_RD;
                ram_oe_n <= 1'b0;
                cnt_q    <= RD_CNT;
              end
            end
          end
        end
        S_RAM_RD: begin
          if (cnt_q == 4'd0) begin
            data_o   <= ram_data;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_be_n <= 4'hF;
            state_q  <= S_DONE;
            ready_o  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RAM_WR: begin
          if (cnt_q == 4'd0) begin
            // we_n rises while ce_n and data stay put, giving the SRAM hold time.
            ram_we_n <= 1'b1;
            state_q  <= S_RAM_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RAM_HOLD: begin
          ram_ce_n <= 1'b1;
          ram_be_n <= 4'hF;
          drv_lo_q <= 1'b0;
          drv_hi_q <= 1'b0;
          state_q  <= S_DONE;
          ready_o  <= 1'b1;
        end
        S_UART_RD: begin
          if (cnt_q == 4'd0) begin
            data_o   <= {24'b0, ram_data[7:0]};
            uart_rdn <= 1'b1;
            state_q  <= S_DONE;
            ready_o  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_UART_WR_WAIT: begin
          // The CPU stalls here for as long as the transmitter stays busy.
          if (uart_tx_idle) begin
            state_q  <= S_UART_WR;
            uart_wrn <= 1'b0;
            drv_lo_q <= 1'b1;
            cnt_q    <= PULSE_CNT;
          end
        end
        S_UART_WR: begin
          if (!uart_wrn) begin
            if (cnt_q == 4'd0) uart_wrn <= 1'b1;  // the next cycle is the release cycle
            else               cnt_q    <= cnt_q - 4'd1;
          end else begin
            drv_lo_q <= 1'b0;
            state_q  <= S_DONE;
            ready_o  <= 1'b1;
          end
        end
        S_DONE: begin
          // ce_i is ignored in this cycle, so a held request is not taken twice.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
